// File: rtl/dut_math_pkg.sv
// Shared types and packed-word field layout for the FIFO output reader.
package dut_math_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_e;

  // Packed FIFO word is {data, last, source_id} with source_id in the LSBs.
  localparam int unsigned SRC_ID_LSB = 0;

  function automatic int unsigned last_bit(input int unsigned id_width);
    return id_width;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned id_width);
    return id_width + 1;
  endfunction

endpackage

// File: rtl/dut_skid_buffer_2e.sv
// Two-entry in-order holding buffer; vacated entries are zeroed so the head reads 0 when empty.
module dut_skid_buffer_2e #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0_r;
  logic [WIDTH-1:0] e1_r;
  logic [1:0]       occ_r;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (occ_r != 2'd0);
  assign push_ok = push && (pop_ok || (occ_r != 2'd2));
  assign occ     = occ_r;
  assign head    = e0_r;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      e0_r  <= '0;
      e1_r  <= '0;
      occ_r <= 2'd0;
    end else if (push_ok && pop_ok) begin
      if (occ_r == 2'd2) begin
        e0_r <= e1_r;
        e1_r <= push_data;
      end else begin
        e0_r <= push_data;
      end
    end else if (pop_ok) begin
      e0_r  <= e1_r;
      e1_r  <= '0;
      occ_r <= occ_r - 2'd1;
    end else if (push_ok) begin
      if (occ_r == 2'd0) begin
        e0_r <= push_data;
      end else begin
        e1_r <= push_data;
      end
      occ_r <= occ_r + 2'd1;
    end
  end

endmodule

// File: rtl/dut_fifo_out_reader.sv
// Drains a 1-cycle-latency FIFO into a ready/valid beat stream, tracking frame length and source-ID consistency.
module dut_fifo_out_reader
  import dut_math_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 64,
  parameter int unsigned IN_INTERFACE_ID_WIDTH = 2,
  parameter int unsigned FRAME_CNT_WIDTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      nreset,
  input  logic [DATA_WIDTH+IN_INTERFACE_ID_WIDTH:0] fifo_data,
  output logic                                      fifo_re,
  input  logic                                      fifo_empty,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [IN_INTERFACE_ID_WIDTH-1:0]          out_data_source_id,
  output logic                                      out_data_last,
  output logic                                      out_data_valid,
  input  logic                                      out_data_ready,
  output logic [FRAME_CNT_WIDTH-1:0]                out_frame_len,
  output logic                                      out_frame_err
);

  localparam int unsigned FIFO_WIDTH = DATA_WIDTH + IN_INTERFACE_ID_WIDTH + 1;
  localparam int unsigned LAST_POS   = last_bit(IN_INTERFACE_ID_WIDTH);
  localparam int unsigned DATA_LSB   = data_lsb(IN_INTERFACE_ID_WIDTH);

  logic [1:0]                       occ_r;
  logic                             rd_pend_r;
  logic [FIFO_WIDTH-1:0]            head;
  logic                             pop_c;
  logic [2:0]                       fill_c;
  frame_state_e                     state_r;
  logic [FRAME_CNT_WIDTH-1:0]       cnt_r;
  logic [FRAME_CNT_WIDTH-1:0]       cnt_inc_c;
  logic [IN_INTERFACE_ID_WIDTH-1:0] frame_id_r;
  logic [IN_INTERFACE_ID_WIDTH-1:0] head_id;
  logic                             head_last;

  assign head_id   = head[SRC_ID_LSB +: IN_INTERFACE_ID_WIDTH];
  assign head_last = head[LAST_POS];

  dut_skid_buffer_2e #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .nreset    (nreset),
    .push      (rd_pend_r),
    .push_data (fifo_data),
    .pop       (pop_c),
    .occ       (occ_r),
    .head      (head)
  );

  // Read request counts the word already in flight so the buffer can never overflow.
  always_comb begin
    out_data_valid = (occ_r != 2'd0);
    pop_c          = out_data_valid && out_data_ready;
    fill_c         = 3'(occ_r) + 3'(rd_pend_r) - 3'(pop_c);
    fifo_re        = nreset && !fifo_empty && (fill_c < 3'd2);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= fifo_re;
    end
  end

  assign cnt_inc_c = (cnt_r == {FRAME_CNT_WIDTH{1'b1}}) ? cnt_r : cnt_r + FRAME_CNT_WIDTH'(1);

  // Frame tracker: advances only on an accepted beat; ID mismatch is reported, never acted on.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      frame_id_r <= '0;
    end else if (pop_c) begin
      case (state_r)
        ST_IDLE: begin
          if (!head_last) begin
            frame_id_r <= head_id;
            cnt_r      <= FRAME_CNT_WIDTH'(1);
            state_r    <= ST_IN_FRAME;
          end
        end
        ST_IN_FRAME: begin
          if (head_last) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_inc_c;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Head entry is zeroed whenever the buffer is empty, so payload fields need no gating.
  always_comb begin
    out_data           = head[DATA_LSB +: DATA_WIDTH];
    out_data_source_id = head_id;
    out_data_last      = head_last;
    out_frame_len      = '0;
    out_frame_err      = 1'b0;
    if (out_data_valid) begin
      out_frame_len = (state_r == ST_IDLE) ? FRAME_CNT_WIDTH'(1) : cnt_inc_c;
      out_frame_err = (state_r == ST_IN_FRAME) && (head_id != frame_id_r);
    end
  end

endmodule

// File: doc/dut_fifo_out_reader.md
DUT_FIFO_OUT_READER -- requirements
Module: dut_fifo_out_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 'x, payload width; the instantiator sets it and it must be >= 36.
REQ-002 SHALL have parameter IN_INTERFACE_ID_WIDTH, default 'x, source ID width; the instantiator sets it.
REQ-003 SHALL have parameter FRAME_CNT_WIDTH, default 16, frame-length counter width.
REQ-004 SHALL have localparam FIFO_WIDTH = DATA_WIDTH + IN_INTERFACE_ID_WIDTH + 1.
REQ-005 clk  input  1  clock; one clock domain, rising edge.
REQ-006 nreset  input  1  asynchronous reset, active low.
REQ-007 fifo_data  input  FIFO_WIDTH  packed word {data, last, source_id}, source_id in the LSBs.
REQ-008 fifo_re  output  1  FIFO pop request.
REQ-009 fifo_empty  input  1  FIFO has no words.
REQ-010 out_data  output  DATA_WIDTH  unpacked payload.
REQ-011 out_data_source_id  output  IN_INTERFACE_ID_WIDTH  unpacked source ID.
REQ-012 out_data_last  output  1  last word of frame.
REQ-013 out_data_valid  output  1  beat available.
REQ-014 out_data_ready  input  1  downstream accepts the beat.
REQ-015 out_frame_len  output  FRAME_CNT_WIDTH  words in current frame, including the current beat.
REQ-016 out_frame_err  output  1  current beat's source ID differs from its frame's first-beat ID.

Function
REQ-017 FIFO read latency SHALL be 1 cycle: fifo_data for fifo_re in cycle N is sampled in cycle N+1.
REQ-018 SHALL hold words in a 2-entry in-order buffer (occ_r 0..2), plus a 1-bit read-in-flight flag rd_pend_r.
REQ-019 Beat SHALL be transferred when out_data_valid && out_data_ready (pop_c); out_data_valid = (occ_r != 0).
REQ-020 fifo_re SHALL be !fifo_empty && (occ_r + rd_pend_r - pop_c) < 2; the combinational path from ready to fifo_re is allowed.
REQ-021 SHALL never overflow the buffer; push and pop in the same cycle leave occ_r unchanged.
REQ-022 Sustained throughput SHALL be 1 beat/cycle when the FIFO is non-empty and ready is held high.
REQ-023 out_data_valid SHALL first rise 2 cycles after the first fifo_re of an idle pipe.
REQ-024 While valid && !ready, out_data, out_data_source_id and out_data_last SHALL stay stable and order SHALL be preserved.
REQ-025 FSM SHALL have states IDLE and IN_FRAME, advancing only on pop_c.
REQ-026 From IDLE, a non-last pop SHALL capture the frame ID and cnt=1, then go to IN_FRAME; a last pop in IDLE is a 1-word frame and stays in IDLE.
REQ-027 In IN_FRAME, each pop SHALL increment cnt, saturating at all-ones; a last pop SHALL return to IDLE.
REQ-028 out_frame_len SHALL be 1 in IDLE and sat(cnt+1) in IN_FRAME, valid whenever out_data_valid is high.
REQ-029 out_frame_err SHALL be 1 only in IN_FRAME when the head ID != the frame ID; it SHALL NOT alter the FSM.
REQ-030 Outputs SHALL be undefined-free: 0 when out_data_valid is low.

Reset
REQ-031 Reset SHALL force occ_r=0, rd_pend_r=0, FSM=IDLE, cnt=0, and buffer contents to 0.
REQ-032 fifo_re SHALL be 0 while nreset is low; out_data_valid, out_frame_err and out_data_last SHALL be 0.
REQ-033 Reset mid-frame SHALL discard buffered and in-flight words; FIFO-side recovery is the system's responsibility.

Structure
REQ-034 The FSM state enum and packed-word field offset constants SHALL live in the shared package dut_math_pkg.
REQ-035 The 2-entry buffer SHALL be the sub-module dut_skid_buffer_2e; the FSM and counters SHALL stay in the top level.

Verification (DATA_WIDTH=64, IN_INTERFACE_ID_WIDTH=2)
REQ-036 Reset with fifo_empty=0 -> fifo_re=0 and out_data_valid=0 throughout; fifo_re=1 in the first cycle after release.
REQ-037 4 words preloaded, ready=1 -> 4 beats on consecutive cycles; the first valid comes 2 cycles after the first fifo_re.
REQ-038 8 words, ready low for 5 cycles -> at most 2 outstanding (occ+pend), no loss, all 8 beats delivered in order.
REQ-039 Frame of 3 words, id=2, last on word 3 -> out_frame_len 1,2,3; FSM back in IDLE; out_frame_err=0.
REQ-040 Frame with ids 1,1,3(last) -> out_frame_err=1 on beat 3 only.
REQ-041 FRAME_CNT_WIDTH=2, 5-word frame -> out_frame_len 1,2,3,3,3.
